// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer: opcodes, functs,
// ALU codes, datapath select values, FSM states and the decoded control vector.
package multicycle_control_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD,
    WB_MEM, MEM_WR, BRANCH, JUMP, JAL, JR, TRAP
  } state_t;

  typedef struct packed {
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } ctrl_t;

  // Instruction dispatch out of DECODE; unknown encodings land in TRAP.
  function automatic state_t decode_next(input logic [5:0] opcode,
                                         input logic [5:0] funct);
    state_t ns;
    ns = TRAP;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: ns = EXEC_R;
          FN_JR:                  ns = JR;
          default:                ns = TRAP;
        endcase
      end
      OPC_LW, OPC_SW:     ns = MEM_ADDR;
      OPC_ADDI, OPC_XORI: ns = EXEC_I;
      OPC_BEQ:            ns = BRANCH;
      OPC_J:              ns = JUMP;
      OPC_JAL:            ns = JAL;
      default:            ns = TRAP;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state-to-control table. Only FETCH (mem_ready) and BRANCH
// (zero) look at live inputs; the rest depend on state and the latched IR.
module control_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: assigning the whole vector first keeps every path fully specified,
    // so no latches are inferred for fields a state does not mention.
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = OP_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = OP_ADD;
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = (funct == FN_SUB) ? OP_SUB :
                         (funct == FN_SLT) ? OP_SLT : OP_ADD;
      end
      WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OPC_XORI) ? OP_XOR : OP_ADD;
      end
      WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = OP_ADD;
      end
      MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = OP_SUB;
        ctrl.pc_source = PC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      JUMP: begin
        ctrl.pc_source = PC_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      JAL: begin
        ctrl.pc_source  = PC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RA;
        ctrl.mem_to_reg = M2R_PC;
      end
      JR: begin
        ctrl.pc_source = PC_RS;
        ctrl.pc_en     = 1'b1;
      end
      TRAP:    ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: state register, next-state logic, retired-instruction
// counter, and the control table with all outputs forced low during reset.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       instruction,
  input  logic [5:0]       instruction_funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t state, next_state;
  ctrl_t  ctrl, gated;
  logic   completing;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (mem_ready) next_state = DECODE;
      DECODE:   next_state = decode_next(instruction, instruction_funct);
      EXEC_R:   next_state = WB_R;
      EXEC_I:   next_state = WB_I;
      MEM_ADDR: next_state = (instruction == OPC_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) next_state = WB_MEM;
      MEM_WR:   if (mem_ready) next_state = FETCH;
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, JR: next_state = FETCH;
      TRAP:     next_state = TRAP;
      default:  next_state = FETCH;
    endcase
  end

  // A FETCH stall loops FETCH->FETCH and is not a completion.
  assign completing = (state != FETCH) && (next_state == FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           retired <= '0;
    else if (completing) retired <= retired + CNT_W'(1);
  end

  control_decode u_decode (
    .state     (state),
    .opcode    (instruction),
    .funct     (instruction_funct),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  // NOTE: gating with reset itself drops in-flight strobes the moment reset
  // rises, without waiting for the state register to settle.
  assign gated = reset ? '0 : ctrl;

  assign i_or_d     = gated.i_or_d;
  assign mem_read   = gated.mem_read;
  assign mem_write  = gated.mem_write;
  assign ir_write   = gated.ir_write;
  assign pc_en      = gated.pc_en;
  assign pc_source  = gated.pc_source;
  assign alu_src_a  = gated.alu_src_a;
  assign alu_src_b  = gated.alu_src_b;
  assign alu_op     = gated.alu_op;
  assign reg_write  = gated.reg_write;
  assign reg_dst    = gated.reg_dst;
  assign mem_to_reg = gated.mem_to_reg;
  assign illegal    = gated.illegal;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the MIPS-subset datapath: the register file, the ALU, a single shared instruction/data memory, the PC, the IR and the ALUOut/MDR latches. A registered FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath mux select and write strobe each cycle, and stalls on a memory ready handshake. It replaces the single-cycle combinational control so that one ALU and one memory port can be shared across cycles.

Parameters:
CNT_W, 32, width of retired-instruction counter
OP_ADD, 3'b000, alu_op code for add
OP_SUB, 3'b001, alu_op code for subtract
OP_XOR, 3'b010, alu_op code for xor
OP_SLT, 3'b011, alu_op code for set-less-than

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH
instruction  in  6  IR[31:26] opcode
instruction_funct  in  6  IR[5:0] funct
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current read/write this cycle
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load IR
pc_en  out  1  load PC
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs value
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_op  out  3  ALU operation code
reg_write  out  1  register file write enable
reg_dst  out  2  00=rt, 01=rd, 10=$31
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
illegal  out  1  sticky undefined-opcode/funct flag
retired  out  CNT_W  instructions completed since reset

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-high.
- Reset response: state=FETCH, retired=0, illegal=0. All outputs are decoded from state; while reset is high every strobe is 0 (mem_read, mem_write, ir_write, pc_en, reg_write) and every select is 0.
- Output timing: Moore outputs, except ir_write and pc_en in FETCH, which are gated by mem_ready.
- FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. ir_write=pc_en=mem_ready. Stay while !mem_ready; go to DECODE on mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - 000000 with funct add(100000)/sub(100010)/slt(101010) -> EXEC_R
  - 000000 with funct jr(001000) -> JR
  - 100011 lw / 101011 sw -> MEM_ADDR
  - 001000 addi / 001110 xori -> EXEC_I
  - 000100 beq -> BRANCH
  - 000010 j -> JUMP
  - 000011 jal -> JAL
  - anything else -> TRAP
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op per funct (ADD/SUB/SLT) -> WB_R.
- WB_R: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=ADD (addi) or XOR (xori) -> WB_I.
- WB_I: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: i_or_d=1, mem_read=1; hold until mem_ready, then -> WB_MEM.
- WB_MEM: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WR: i_or_d=1, mem_write=1; hold until mem_ready, then -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01, pc_en=zero -> FETCH.
- JUMP: pc_source=10, pc_en=1 -> FETCH.
- JAL: pc_source=10, pc_en=1, reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH.
- JR: pc_source=11, pc_en=1 -> FETCH.
- TRAP: illegal=1; all strobes 0; terminal until reset.
- Memory requests: mem_read and mem_write are never high together. A request stays asserted and stable until the mem_ready cycle. mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- retired: increments by 1 on each transition into FETCH from a completing state. Wraps modulo 2^CNT_W. Never increments in TRAP.
- Mid-instruction reset: aborts immediately; there are no partial writes after reset assertion.

Decomposition:
- Shared package: opcode and funct constants, alu_op codes, state encoding (4-bit enum, 15 states), and select encodings for pc_source, alu_src_b, reg_dst and mem_to_reg.
- Natural sub-module: control_decode, a combinational state-to-output-vector table, kept separate from the next-state/counter logic.

Test Plan:
1. Reset then add, mem_ready tied 1 -> FETCH, DECODE, EXEC_R (alu_op=000), WB_R (reg_write=1, reg_dst=01); 4 cycles; retired=1.
2. lw with mem_ready low 3 cycles in MEM_RD -> mem_read=1, i_or_d=1 held 4 cycles; WB_MEM has mem_to_reg=01; total 5+3 cycles.
3. beq with zero=1, then beq with zero=0 -> pc_en=1, pc_source=01 in the first BRANCH; pc_en=0 in the second; retired increments by 2.
4. xori then jal -> EXEC_I alu_op=010, alu_src_b=10; JAL has reg_dst=10, mem_to_reg=10, pc_source=10, pc_en=1 in one cycle.
5. Opcode 111111 -> TRAP, illegal=1; strobes 0 for 20 cycles; retired unchanged; reset clears illegal and returns to FETCH.
6. Reset asserted mid-MEM_WR (between clock edges) -> mem_write drops asynchronously; next cycle FETCH with retired=0.
